// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : Carries each conditional branch's 2-bit-predictor prediction
//               from ID into EX, compares it with the actual outcome, reports
//               branch/miss back to the predictor and issues a one-cycle
//               flush with the corrected fetch PC on a misprediction.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Configuration macro:
//   BRU_STATS_EN  - adds saturating branch/miss statistics counters and the
//                   stat_branches / stat_misses output ports.
// ----------------------------------------------------------------------------
// Parameters:
//   ADDR_W - width of PC / target addresses
//   STAT_W - width of statistics counters (only used with BRU_STATS_EN)
// Ports:
//   clk           in   core clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   stall         in   global pipeline stall; holds the EX register
//   id_branch     in   conditional branch decoded in ID this cycle
//   id_pred       in   prediction for the ID branch (1 = taken)
//   id_pc4        in   PC+4 of the ID branch (not-taken path)
//   id_target     in   target of the ID branch (taken path)
//   ex_taken      in   actual outcome from the EX comparator
//   branch        out  resolved branch present in EX
//   miss          out  EX branch mispredicted
//   flush         out  squash IF/ID and redirect fetch this cycle
//   redirect_pc   out  correct next-fetch PC, meaningful when flush=1
//   stat_branches out  resolved branch count   (BRU_STATS_EN only)
//   stat_misses   out  misprediction count     (BRU_STATS_EN only)
// ============================================================================
module branch_resolve_unit #(
    parameter int ADDR_W = 32,
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              id_branch,
    input  logic              id_pred,
    input  logic [ADDR_W-1:0] id_pc4,
    input  logic [ADDR_W-1:0] id_target,
    input  logic              ex_taken,
    output logic              branch,
    output logic              miss,
    output logic              flush,
    output logic [ADDR_W-1:0] redirect_pc
`ifdef BRU_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_misses
`endif
);

    // EX-stage copy of the branch and its prediction
    logic              ex_valid_q, ex_valid_d;
    logic              ex_pred_q,  ex_pred_d;
    logic [ADDR_W-1:0] ex_pc4_q,   ex_pc4_d;
    logic [ADDR_W-1:0] ex_target_q, ex_target_d;

    // A branch sitting in ID while we flush is on the wrong path: it enters
    // EX as a bubble so the predictor never hears about it.
    always_comb begin
        ex_valid_d  = id_branch & ~flush;
        ex_pred_d   = id_pred;
        ex_pc4_d    = id_pc4;
        ex_target_d = id_target;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_pred_q   <= 1'b0;
            ex_pc4_q    <= '0;
            ex_target_q <= '0;
        end else if (!stall) begin
            ex_valid_q  <= ex_valid_d;
            ex_pred_q   <= ex_pred_d;
            ex_pc4_q    <= ex_pc4_d;
            ex_target_q <= ex_target_d;
        end
    end

    // flush is held off during a stall; since the EX register also holds,
    // the pending miss fires exactly once, in the first unstalled cycle.
    always_comb begin
        branch      = ex_valid_q;
        miss        = ex_valid_q & (ex_pred_q ^ ex_taken);
        flush       = miss & ~stall;
        redirect_pc = ex_taken ? ex_target_q : ex_pc4_q;
    end

`ifdef BRU_STATS_EN
    localparam logic [STAT_W-1:0] STAT_INC = {{(STAT_W-1){1'b0}}, 1'b1};

    logic [STAT_W-1:0] stat_branches_q;
    logic [STAT_W-1:0] stat_misses_q;

    // Counted on the same condition the predictor updates on, so each
    // branch contributes once; both counters stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches_q <= '0;
            stat_misses_q   <= '0;
        end else begin
            if (branch && !stall && !(&stat_branches_q))
                stat_branches_q <= stat_branches_q + STAT_INC;
            if (miss && !stall && !(&stat_misses_q))
                stat_misses_q <= stat_misses_q + STAT_INC;
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_misses   = stat_misses_q;
`else
    // STAT_W has no function without the statistics counters
    logic unused_stat_w;
    assign unused_stat_w = (STAT_W > 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_unit
// Description : Directed self-checking bench for branch_resolve_unit.
//               Inputs change on the falling edge; outputs are sampled 1ns
//               later, well away from the rising (active) edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        id_branch;
    logic        id_pred;
    logic [31:0] id_pc4;
    logic [31:0] id_target;
    logic        ex_taken;
    logic        branch;
    logic        miss;
    logic        flush;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;

`ifdef BRU_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_misses;
    logic        b4_branch, b4_miss, b4_flush;
    logic [31:0] b4_redirect_pc;
    logic [3:0]  b4_stat_branches;
    logic [3:0]  b4_stat_misses;
`endif

    branch_resolve_unit #(.ADDR_W(32), .STAT_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .id_branch   (id_branch),
        .id_pred     (id_pred),
        .id_pc4      (id_pc4),
        .id_target   (id_target),
        .ex_taken    (ex_taken),
        .branch      (branch),
        .miss        (miss),
        .flush       (flush),
        .redirect_pc (redirect_pc)
`ifdef BRU_STATS_EN
        ,
        .stat_branches (stat_branches),
        .stat_misses   (stat_misses)
`endif
    );

`ifdef BRU_STATS_EN
    // Narrow-counter instance sharing the same stimulus, for saturation
    branch_resolve_unit #(.ADDR_W(32), .STAT_W(4)) dut4 (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .id_branch     (id_branch),
        .id_pred       (id_pred),
        .id_pc4        (id_pc4),
        .id_target     (id_target),
        .ex_taken      (ex_taken),
        .branch        (b4_branch),
        .miss          (b4_miss),
        .flush         (b4_flush),
        .redirect_pc   (b4_redirect_pc),
        .stat_branches (b4_stat_branches),
        .stat_misses   (b4_stat_misses)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a branch in ID (applied on the falling edge)
    task automatic put_branch(input logic pred, input logic [31:0] pc4,
                              input logic [31:0] tgt);
        id_branch = 1'b1;
        id_pred   = pred;
        id_pc4    = pc4;
        id_target = tgt;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; id_branch = 1'b0; id_pred = 1'b0;
        id_pc4 = '0; id_target = '0; ex_taken = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (branch !== 1'b0 || miss !== 1'b0 || flush !== 1'b0 || redirect_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_initial: branch=%b miss=%b flush=%b redirect_pc=%h, required 0/0/0/0",
                     branch, miss, flush, redirect_pc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // load a mispredicting branch, then pull reset mid-cycle
        put_branch(1'b0, 32'h0000_0010, 32'h0000_0055);
        @(negedge clk);
        id_branch = 1'b0; ex_taken = 1'b1; #1;
        checks++;
        if (branch !== 1'b1 || miss !== 1'b1 || redirect_pc !== 32'h55) begin
            errors++;
            $display("FAIL reset_preload: branch=%b miss=%b redirect_pc=%h, required 1/1/00000055",
                     branch, miss, redirect_pc);
        end
        #1 rst_n = 1'b0; #1;
        checks++;
        if (branch !== 1'b0 || miss !== 1'b0 || flush !== 1'b0 || redirect_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_async: branch=%b miss=%b flush=%b redirect_pc=%h, required 0/0/0/0",
                     branch, miss, flush, redirect_pc);
        end
        @(negedge clk);
        rst_n = 1'b1; ex_taken = 1'b0;
    endtask

    task automatic test_correct_taken();
        @(negedge clk);
        put_branch(1'b1, 32'h0000_0014, 32'h0000_0040);
        @(negedge clk);
        id_branch = 1'b0; ex_taken = 1'b1; #1;
        checks++;
        if (branch !== 1'b1 || miss !== 1'b0 || flush !== 1'b0 || redirect_pc !== 32'h40) begin
            errors++;
            $display("FAIL correct_taken: branch=%b miss=%b flush=%b redirect_pc=%h, required 1/0/0/00000040",
                     branch, miss, flush, redirect_pc);
        end
        @(negedge clk); #1;
        checks++;
        if (branch !== 1'b0) begin
            errors++;
            $display("FAIL correct_taken_single: branch=%b, required 0", branch);
        end
    endtask

    task automatic test_mispredict_not_taken();
        @(negedge clk);
        put_branch(1'b1, 32'h0000_0024, 32'h0000_0080);
        @(negedge clk);
        id_branch = 1'b0; ex_taken = 1'b0; #1;
        checks++;
        if (branch !== 1'b1 || miss !== 1'b1 || flush !== 1'b1 || redirect_pc !== 32'h24) begin
            errors++;
            $display("FAIL mispredict_nt: branch=%b miss=%b flush=%b redirect_pc=%h, required 1/1/1/00000024",
                     branch, miss, flush, redirect_pc);
        end
        @(negedge clk); #1;
        checks++;
        if (flush !== 1'b0 || branch !== 1'b0) begin
            errors++;
            $display("FAIL mispredict_nt_once: flush=%b branch=%b, required 0/0", flush, branch);
        end
    endtask

    task automatic test_wrong_path();
        @(negedge clk);
        put_branch(1'b0, 32'h0000_0030, 32'h0000_0100);
        @(negedge clk);
        ex_taken = 1'b1;
        put_branch(1'b1, 32'h0000_0104, 32'h0000_0200);  // wrong-path branch
        #1;
        checks++;
        if (miss !== 1'b1 || flush !== 1'b1 || redirect_pc !== 32'h100) begin
            errors++;
            $display("FAIL wrong_path_flush: miss=%b flush=%b redirect_pc=%h, required 1/1/00000100",
                     miss, flush, redirect_pc);
        end
        @(negedge clk);
        id_branch = 1'b0; #1;
        checks++;
        if (branch !== 1'b0 || miss !== 1'b0 || flush !== 1'b0) begin
            errors++;
            $display("FAIL wrong_path_bubble: branch=%b miss=%b flush=%b, required 0/0/0",
                     branch, miss, flush);
        end
    endtask

    task automatic test_stall_miss();
        @(negedge clk);
        put_branch(1'b1, 32'h0000_0060, 32'h0000_0090);
        @(negedge clk);
        id_branch = 1'b0; ex_taken = 1'b0; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if (miss !== 1'b1 || flush !== 1'b0 || branch !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: branch=%b miss=%b flush=%b, required 1/1/0",
                         i, branch, miss, flush);
            end
        end
        @(negedge clk);
        stall = 1'b0; #1;
        checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'h60) begin
            errors++;
            $display("FAIL stall_release: flush=%b redirect_pc=%h, required 1/00000060",
                     flush, redirect_pc);
        end
        @(negedge clk); #1;
        checks++;
        if (flush !== 1'b0 || branch !== 1'b0) begin
            errors++;
            $display("FAIL stall_flush_once: flush=%b branch=%b, required 0/0", flush, branch);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        put_branch(1'b1, 32'h0000_00A4, 32'h0000_00A0);
        @(negedge clk);
        ex_taken = 1'b1;
        put_branch(1'b0, 32'h0000_00B4, 32'h0000_00F0);
        #1;
        checks++;
        if (branch !== 1'b1 || miss !== 1'b0 || flush !== 1'b0 || redirect_pc !== 32'hA0) begin
            errors++;
            $display("FAIL b2b_first: branch=%b miss=%b flush=%b redirect_pc=%h, required 1/0/0/000000a0",
                     branch, miss, flush, redirect_pc);
        end
        @(negedge clk);
        ex_taken = 1'b0;
        put_branch(1'b1, 32'h0000_00C4, 32'h0000_00C0);
        #1;
        checks++;
        if (branch !== 1'b1 || miss !== 1'b0 || flush !== 1'b0 || redirect_pc !== 32'hB4) begin
            errors++;
            $display("FAIL b2b_second: branch=%b miss=%b flush=%b redirect_pc=%h, required 1/0/0/000000b4",
                     branch, miss, flush, redirect_pc);
        end
        @(negedge clk);
        ex_taken = 1'b1; id_branch = 1'b0; #1;
        checks++;
        if (branch !== 1'b1 || miss !== 1'b0 || flush !== 1'b0 || redirect_pc !== 32'hC0) begin
            errors++;
            $display("FAIL b2b_third: branch=%b miss=%b flush=%b redirect_pc=%h, required 1/0/0/000000c0",
                     branch, miss, flush, redirect_pc);
        end
        @(negedge clk);
        ex_taken = 1'b0;
    endtask

`ifdef BRU_STATS_EN
    // One isolated branch: present, resolve, then an idle cycle
    task automatic one_branch(input logic pred, input logic taken);
        @(negedge clk);
        put_branch(pred, 32'h0000_0200, 32'h0000_0300);
        @(negedge clk);
        id_branch = 1'b0; ex_taken = taken;
        @(negedge clk);
        ex_taken = 1'b0;
    endtask

    task automatic test_stats();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (stat_branches !== 32'd0 || stat_misses !== 32'd0) begin
            errors++;
            $display("FAIL stats_reset: branches=%0d misses=%0d, required 0/0",
                     stat_branches, stat_misses);
        end
        rst_n = 1'b1;
        one_branch(1'b1, 1'b1);
        one_branch(1'b1, 1'b0);   // miss
        one_branch(1'b0, 1'b0);
        one_branch(1'b0, 1'b1);   // miss
        one_branch(1'b1, 1'b1);
        #1;
        checks++;
        if (stat_branches !== 32'd5 || stat_misses !== 32'd2) begin
            errors++;
            $display("FAIL stats_count: branches=%0d misses=%0d, required 5/2",
                     stat_branches, stat_misses);
        end
        for (int i = 0; i < 15; i++) one_branch(1'b1, 1'b1);
        #1;
        checks++;
        if (b4_stat_branches !== 4'd15 || b4_stat_misses !== 4'd2) begin
            errors++;
            $display("FAIL stats_saturate: branches=%0d misses=%0d, required 15/2",
                     b4_stat_branches, b4_stat_misses);
        end
        checks++;
        if (stat_branches !== 32'd20) begin
            errors++;
            $display("FAIL stats_wide: branches=%0d, required 20", stat_branches);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_correct_taken();
        test_mispredict_not_taken();
        test_wrong_path();
        test_stall_miss();
        test_back_to_back();
`ifdef BRU_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
